// File: rtl/jlapane_div4_if.sv
// rtl/jlapane_div4_if.sv - start/operand/result bundle for the 8-by-4 restoring divider
interface jlapane_div4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  // Requester side: issues start with operands, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/jlapane_div4.sv
// rtl/jlapane_div4.sv - 8-bit by 4-bit restoring divider, one quotient bit per cycle (option macro JLAPANE_DIV4_DBZ_EN: fast divide-by-zero)
module jlapane_div4 (
  input  logic          clk,
  input  logic          rst_n,
  jlapane_div4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;

  // Working registers: dvd_q shifts dividend bits out of its MSB while
  // quotient bits enter at its LSB, so after 8 steps it holds the quotient.
  logic [7:0] dvd_q;
  logic [3:0] dvs_q;
  logic [3:0] rem_q;
  logic [2:0] cnt_q;

  // Result registers, held from one done to the next.
  logic [7:0] quo_q;
  logic [3:0] rmd_q;

  logic       accept;
  logic       last_iter;
  logic       fast_dbz;
  logic [4:0] shifted;
  logic       qbit;
  logic [3:0] rem_nxt;
  logic [7:0] dvd_nxt;

  // DONE is not busy, so a start in the done cycle chains straight into CALC.
  assign accept    = bus.start && (state != CALC);
  assign last_iter = (cnt_q == 3'd7);

  // 5-bit trial remainder: previous remainder with the next dividend bit appended.
  // When the trial succeeds the difference is below the divisor, so the
  // 4-bit subtraction is exact. A zero divisor always succeeds, giving
  // quotient 0xFF and leaving dividend[3:0] as the remainder.
  assign shifted = {rem_q, dvd_q[7]};
  assign qbit    = (shifted >= {1'b0, dvs_q});
  assign rem_nxt = qbit ? (shifted[3:0] - dvs_q) : shifted[3:0];
  assign dvd_nxt = {dvd_q[6:0], qbit};

`ifdef JLAPANE_DIV4_DBZ_EN
  logic dbz_q;

  assign fast_dbz = (dvs_q == 4'd0);
`else
  assign fast_dbz = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: 8 CALC cycles (or 1 with fast zero-divisor), one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (fast_dbz || last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch and shift-subtract iteration; results load on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= 8'd0;
      dvs_q <= 4'd0;
      rem_q <= 4'd0;
      cnt_q <= 3'd0;
      quo_q <= 8'd0;
      rmd_q <= 4'd0;
    end else if (accept) begin
      dvd_q <= bus.dividend;
      dvs_q <= bus.divisor;
      rem_q <= 4'd0;
      cnt_q <= 3'd0;
    end else if (state == CALC) begin
      if (fast_dbz) begin
        // No iteration has run, so dvd_q still holds the original dividend.
        quo_q <= 8'hFF;
        rmd_q <= dvd_q[3:0];
      end else begin
        dvd_q <= dvd_nxt;
        rem_q <= rem_nxt;
        cnt_q <= cnt_q + 3'd1;
        if (last_iter) begin
          quo_q <= dvd_nxt;
          rmd_q <= rem_nxt;
        end
      end
    end
  end

`ifdef JLAPANE_DIV4_DBZ_EN
  // Divide-by-zero flag, updated alongside the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else if (!accept && (state == CALC)) begin
      if (fast_dbz) begin
        dbz_q <= 1'b1;
      end else if (last_iter) begin
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.busy      = (state == CALC);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_jlapane_div4.sv
// tb/tb_jlapane_div4.sv - scoreboard bench for jlapane_div4: directed cases, exhaustive sweep, random traffic
module tb_jlapane_div4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jlapane_div4_if bus ();

  jlapane_div4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef JLAPANE_DIV4_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int next_ok  = 0;

  logic [7:0] last_q;
  logic [3:0] last_r;
  logic       last_dbz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int latency(input logic [3:0] b);
    return (DBZ_EN && (b == 4'd0)) ? 1 : 8;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one start cycle; the reference model decides whether the block is
  // free to take it and, if so, queues the expected result and done cycle.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    int   k;
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    k            = cyc;
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    if (k >= next_ok) begin
      e.a   = a;
      e.b   = b;
      e.q   = (b == 4'd0) ? 8'hFF : 8'(a / b);
      e.r   = (b == 4'd0) ? a[3:0] : 4'(a % b);
      e.dbz = DBZ_EN && (b == 4'd0);
      e.cyc = k + latency(b);
      sb.push_back(e);
      next_ok = k + latency(b) + 1;
    end
  endtask

  task automatic directed(input logic [7:0] a, input logic [3:0] b);
    start_op(a, b);
    idle(latency(b));
    check("done_at_latency", bus.done, 1);
    idle(1);
  endtask

  // Monitor: reset values, result checks on done, hold between dones.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_dbz", bus.div_by_zero, 0);
      last_q   = 8'd0;
      last_r   = 4'd0;
      last_dbz = 1'b0;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", bus.done, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", bus.quotient, e.q);
        check("remainder", bus.remainder, e.r);
        check("div_by_zero", bus.div_by_zero, e.dbz);
        check("done_cycle", cyc, e.cyc);
        if (e.b != 4'd0) begin
          check("q_times_d_plus_r", int'(bus.quotient) * int'(e.b) + int'(bus.remainder), e.a);
          check("rem_below_div", bus.remainder < e.b, 1);
        end
        last_q   = bus.quotient;
        last_r   = bus.remainder;
        last_dbz = bus.div_by_zero;
      end
    end else begin
      check("hold_quotient", bus.quotient, last_q);
      check("hold_remainder", bus.remainder, last_r);
      check("hold_dbz", bus.div_by_zero, last_dbz);
    end
  end

  initial begin
    int wait_cycles;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // 200/7 with busy profile across the eight CALC cycles.
    start_op(8'd200, 4'd7);
    for (int i = 0; i < 8; i++) begin
      check("busy_during_calc", bus.busy, 1);
      idle(1);
    end
    check("busy_after_calc", bus.busy, 0);
    check("done_200_7", bus.done, 1);
    idle(1);

    directed(8'd255, 4'd1);
    directed(8'd15, 4'd15);
    directed(8'd0, 4'd9);
    directed(8'hA7, 4'd0);

    // Second start while busy must be ignored.
    start_op(8'd100, 4'd3);
    idle(2);
    start_op(8'd50, 4'd5);
    idle(8);

    // Back-to-back: start asserted in the done cycle.
    start_op(8'd100, 4'd3);
    idle(8);
    check("b2b_first_done", bus.done, 1);
    start_op(8'd50, 4'd5);
    idle(8);
    check("b2b_second_done", bus.done, 1);
    idle(1);

    // Reset during CALC aborts; block restarts cleanly afterwards.
    start_op(8'd200, 4'd7);
    idle(3);
    rst_n = 1'b0;
    sb.delete();
    next_ok = 0;
    idle(2);
    rst_n = 1'b1;
    start_op(8'd9, 4'd2);
    idle(9);

    // Exhaustive sweep, back-to-back.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(a[7:0], b[3:0]);
        idle(latency(b[3:0]));
      end
    end

    // Random traffic with random gaps, including starts while busy.
    for (int n = 0; n < 300; n++) begin
      start_op(8'($urandom), 4'($urandom));
      idle($urandom_range(0, 10));
    end

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      idle(1);
      wait_cycles++;
    end
    check("scoreboard_drained", sb.size(), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jlapane_div4.md
JLAPANE_DIV4 -- requirements
Module: jlapane_div4

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Port list:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a division; sampled on a clk rising edge
- dividend  input  8  unsigned dividend
- divisor  input  4  unsigned divisor
- quotient  output  8  unsigned quotient, registered
- remainder  output  4  unsigned remainder, registered
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse; results valid
- div_by_zero  output  1  registered; divisor was 0 for the last result
REQ-003 The block SHALL have no parameters: widths are fixed at 8-bit dividend and 4-bit divisor, the inverse of the team's 4x4 multiplier.

Function
REQ-004 The block SHALL implement a restoring shift-subtract divider that resolves one quotient bit per cycle, MSB first.
REQ-005 The block SHALL use a 5-bit partial remainder, so that each trial is {rem[3:0], next dividend bit} minus {1'b0, divisor}.
REQ-006 The state machine SHALL have three states:
- IDLE: on start=1, go to CALC.
- CALC: after 8 iterations, go to DONE.
- DONE: one cycle, then go to IDLE.
REQ-007 A start SHALL be accepted only when busy=0; at acceptance, dividend and divisor SHALL be latched internally, busy SHALL go to 1, and the bit counter SHALL be cleared.
REQ-008 A start with busy=1 SHALL be ignored, and the latched operands SHALL NOT change.
REQ-009 Latency: for a start accepted at edge k, quotient and remainder SHALL update and done SHALL be 1 after edge k+8.
REQ-010 busy SHALL be 1 after edges k through k+7 and 0 from edge k+8 onward.
REQ-011 done SHALL be high for exactly one cycle per accepted start.
REQ-012 quotient, remainder and div_by_zero SHALL hold their values from done until the next done.
REQ-013 A start asserted in the same cycle that done is high SHALL be accepted (back-to-back operation).
REQ-014 Results SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor, for every divisor != 0.
REQ-015 For divisor == 0, the block SHALL return quotient = 8'hFF and remainder = dividend[3:0].

Reset
REQ-016 While rst_n=0, the state SHALL be IDLE and quotient, remainder, busy, done, div_by_zero and all internal registers SHALL be 0.
REQ-017 A reset asserted during CALC SHALL abort the division, produce no done pulse, and leave the block ready for start on the first edge after rst_n rises.

Configuration
REQ-018 The macro JLAPANE_DIV4_DBZ_EN SHALL control fast divide-by-zero handling, as follows.
REQ-019 With JLAPANE_DIV4_DBZ_EN defined, a start accepted with divisor==0 SHALL skip CALC: done=1 and div_by_zero=1 after edge k+1, with the results of REQ-015.
REQ-020 With JLAPANE_DIV4_DBZ_EN defined, div_by_zero SHALL be 0 for every nonzero divisor.
REQ-021 With JLAPANE_DIV4_DBZ_EN undefined, divisor==0 SHALL run the full 8 cycles and produce the results of REQ-015 through the normal datapath.
REQ-022 With JLAPANE_DIV4_DBZ_EN undefined, div_by_zero SHALL be tied to 0.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- dividend=200, divisor=7 -> quotient=8'h1C, remainder=4, done 8 cycles after acceptance, busy high 8 cycles.
- 255/1 -> quotient=8'hFF, remainder=0.
- 15/15 -> quotient=1, remainder=0.
- 0/9 -> quotient=0, remainder=0.
- 8'hA7/0 with macro defined -> quotient=8'hFF, remainder=7, div_by_zero=1, done after 1 cycle.
- 8'hA7/0 with macro undefined -> same quotient and remainder, div_by_zero=0, done after 8 cycles.
- start with 100/3, then start again 3 cycles later with 50/5 -> second start ignored; result quotient=33, remainder=1.
- Back-to-back: start with 100/3, then assert start with 50/5 in the cycle done is high -> 50/5 accepted; quotient=10, remainder=0 eight cycles later.
- rst_n pulsed low 4 cycles after start with 200/7 -> all outputs 0, no done pulse; a new 9/2 afterwards -> quotient=4, remainder=1.
REQ-024 The bench SHALL run an exhaustive sweep of all 4096 operand pairs and check REQ-014 and REQ-015 for each.
